// File: rtl/test_06_resp_misr.sv
// test_06_resp_misr: folds a fixed number of 15-bit responses from the
// test_06 combinational block into a Galois MISR and registers a single
// pass/fail verdict against a golden signature at the end of each run.
module test_06_resp_misr #(
    parameter int unsigned          WIDTH        = 15,
    parameter int unsigned          NUM_PATTERNS = 1024,
    parameter logic [WIDTH-1:0]     POLY         = 'h0003,
    parameter logic [WIDTH-1:0]     SEED         = '0,
    parameter int unsigned          CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             resp_ready,
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;

    logic [WIDTH-1:0] sig_next;
    logic             accept;

    // One MISR step: shift with Galois feedback, then fold in the response
    always_comb begin
        sig_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ resp_data;
    end

    assign accept = (state_q == S_RUN) && resp_valid;

    // Next-state logic for run control, signature, counter and verdict
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    sig_d = sig_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                        pass_d  = (sig_next == golden);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset discards any partial run
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    // Status outputs are pure decodes of registered state
    assign resp_ready = (state_q == S_RUN);
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign pass       = pass_q;
    assign signature  = sig_q;
    assign count      = cnt_q;

endmodule

// File: tb/tb_test_06_resp_misr.sv
// Bench for test_06_resp_misr: three instances (2, 3 and 1024 patterns)
// driven one at a time; a driver pushes expectations from a reference
// model and an independent monitor pops and checks them.
module tb_test_06_resp_misr;

    localparam logic [14:0] POLY = 15'h0003;
    localparam logic [14:0] SEED = 15'h0000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       start_v = '0;
    logic [2:0]       valid_v = '0;
    logic [2:0][14:0] data_v  = '0;
    logic [2:0][14:0] gold_v  = '0;
    logic [2:0]       ready_w, busy_w, done_w, pass_w;
    logic [2:0][14:0] sig_w;
    logic [2:0][15:0] cnt_w;
    logic [1:0]       cnt2, cnt3;
    logic [10:0]      cnt1k;

    int unsigned np [3] = '{2, 3, 1024};

    always #5 clk = ~clk;

    test_06_resp_misr #(.WIDTH(15), .NUM_PATTERNS(2), .POLY(POLY), .SEED(SEED)) u_np2 (
        .clk(clk), .rst(rst), .start(start_v[0]), .resp_valid(valid_v[0]),
        .resp_data(data_v[0]), .resp_ready(ready_w[0]), .golden(gold_v[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .signature(sig_w[0]), .count(cnt2));

    test_06_resp_misr #(.WIDTH(15), .NUM_PATTERNS(3), .POLY(POLY), .SEED(SEED)) u_np3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .resp_valid(valid_v[1]),
        .resp_data(data_v[1]), .resp_ready(ready_w[1]), .golden(gold_v[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .signature(sig_w[1]), .count(cnt3));

    test_06_resp_misr #(.WIDTH(15), .NUM_PATTERNS(1024), .POLY(POLY), .SEED(SEED)) u_np1k (
        .clk(clk), .rst(rst), .start(start_v[2]), .resp_valid(valid_v[2]),
        .resp_data(data_v[2]), .resp_ready(ready_w[2]), .golden(gold_v[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .signature(sig_w[2]), .count(cnt1k));

    assign cnt_w[0] = 16'(cnt2);
    assign cnt_w[1] = 16'(cnt3);
    assign cnt_w[2] = 16'(cnt1k);

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int unsigned inst;
        logic [14:0] sig;
        int unsigned cnt;
        logic        pass;
    } exp_t;

    exp_t acc_q[$];
    exp_t done_q[$];

    // Reference model: 0 = idle, 1 = run, 2 = done
    int unsigned m_state [3] = '{0, 0, 0};
    logic [14:0] m_sig   [3] = '{15'h0, 15'h0, 15'h0};
    int unsigned m_cnt   [3] = '{0, 0, 0};

    // Multiply signature by x modulo x^15 + x + 1, then add the response
    function automatic logic [14:0] mstep(logic [14:0] s, logic [14:0] d);
        int unsigned v;
        v = 32'(s) * 2;
        if (v >= 32768) v = (v - 32768) ^ 32'(POLY);
        return 15'(v) ^ d;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(int unsigned n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(int unsigned cycles);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_state[i] = 0;
            m_sig[i]   = SEED;
            m_cnt[i]   = 0;
        end
        tick(cycles);
        rst = 1'b0;
    endtask

    task automatic pulse_start(int unsigned i);
        start_v[i] = 1'b1;
        if (m_state[i] != 1) begin
            m_state[i] = 1;
            m_sig[i]   = SEED;
            m_cnt[i]   = 0;
        end
        tick();
        start_v[i] = 1'b0;
    endtask

    task automatic send(int unsigned i, logic [14:0] d);
        exp_t e;
        int unsigned k;
        valid_v[i] = 1'b1;
        data_v[i]  = d;
        k = 0;
        while (!ready_w[i] && k < 50) begin
            tick();
            k++;
        end
        if (!ready_w[i]) begin
            chk("ready_timeout", 32'(ready_w[i]), 32'd1);
            valid_v[i] = 1'b0;
            return;
        end
        m_sig[i] = mstep(m_sig[i], d);
        m_cnt[i]++;
        e.inst = i; e.sig = m_sig[i]; e.cnt = m_cnt[i]; e.pass = 1'b0;
        acc_q.push_back(e);
        if (m_cnt[i] == np[i]) begin
            m_state[i] = 2;
            e.pass = (m_sig[i] == gold_v[i]);
            done_q.push_back(e);
        end
        tick();
        valid_v[i] = 1'b0;
        data_v[i]  = $urandom_range(32767);
    endtask

    task automatic wait_done(int unsigned i, int unsigned budget);
        int unsigned k;
        k = 0;
        while (!done_w[i] && k < budget) begin
            tick();
            k++;
        end
        chk("done_timeout", 32'(done_w[i]), 32'd1);
    endtask

    // Monitor: pops an expectation whenever a DUT accepts or raises done
    initial begin
        logic [2:0] acc, dprev;
        exp_t e;
        forever begin
            @(posedge clk);
            acc   = valid_v & ready_w;
            dprev = done_w;
            #1;
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    if (acc_q.size() == 0) begin
                        chk("unexpected_accept", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        e = acc_q.pop_front();
                        chk("acc_inst", 32'(i), e.inst);
                        chk("acc_signature", 32'(sig_w[i]), 32'(e.sig));
                        chk("acc_count", 32'(cnt_w[i]), e.cnt);
                    end
                end
                if (!dprev[i] && done_w[i] && !rst) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        e = done_q.pop_front();
                        chk("done_inst", 32'(i), e.inst);
                        chk("done_signature", 32'(sig_w[i]), 32'(e.sig));
                        chk("done_count", 32'(cnt_w[i]), e.cnt);
                        chk("done_pass", 32'(pass_w[i]), 32'(e.pass));
                        chk("done_busy_low", 32'(busy_w[i]), 32'd0);
                        chk("done_ready_low", 32'(ready_w[i]), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [14:0] vec [1024];
    logic [14:0] ref_sig;

    initial begin
        tick();
        // Reset values on all instances
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            chk("rst_signature", 32'(sig_w[i]), 32'(SEED));
            chk("rst_count", 32'(cnt_w[i]), 32'd0);
            chk("rst_busy", 32'(busy_w[i]), 32'd0);
            chk("rst_done", 32'(done_w[i]), 32'd0);
            chk("rst_pass", 32'(pass_w[i]), 32'd0);
            chk("rst_ready", 32'(ready_w[i]), 32'd0);
        end

        // resp_valid while idle has no effect
        valid_v[0] = 1'b1;
        data_v[0]  = 15'h0005;
        tick(2);
        valid_v[0] = 1'b0;
        chk("idle_valid_signature", 32'(sig_w[0]), 32'h0);
        chk("idle_valid_count", 32'(cnt_w[0]), 32'd0);

        // Basic pass, 2 patterns
        gold_v[0] = 15'h4002;
        pulse_start(0);
        chk("start_busy", 32'(busy_w[0]), 32'd1);
        chk("start_ready", 32'(ready_w[0]), 32'd1);
        send(0, 15'h0001);
        chk("basic_sig1", 32'(sig_w[0]), 32'h0001);
        send(0, 15'h4000);
        chk("basic_done", 32'(done_w[0]), 32'd1);
        chk("basic_pass", 32'(pass_w[0]), 32'd1);
        chk("basic_sig2", 32'(sig_w[0]), 32'h4002);

        // Start from DONE reloads, then a stalled run to the same result
        pulse_start(0);
        chk("restart_done", 32'(done_w[0]), 32'd0);
        chk("restart_count", 32'(cnt_w[0]), 32'd0);
        chk("restart_sig", 32'(sig_w[0]), 32'(SEED));
        chk("restart_busy", 32'(busy_w[0]), 32'd1);
        send(0, 15'h0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_count", 32'(cnt_w[0]), 32'd1);
        end
        send(0, 15'h4000);
        chk("stall_sig", 32'(sig_w[0]), 32'h4002);
        chk("stall_pass", 32'(pass_w[0]), 32'd1);

        // Feedback path and failing verdict, 3 patterns; start mid-run ignored
        gold_v[1] = 15'h0007;
        pulse_start(1);
        send(1, 15'h4000);
        chk("fb_sig1", 32'(sig_w[1]), 32'h4000);
        pulse_start(1);
        chk("midrun_start_count", 32'(cnt_w[1]), 32'd1);
        chk("midrun_start_sig", 32'(sig_w[1]), 32'h4000);
        send(1, 15'h0000);
        chk("fb_sig2", 32'(sig_w[1]), 32'h0003);
        send(1, 15'h0000);
        chk("fb_sig3", 32'(sig_w[1]), 32'h0006);
        chk("fb_done", 32'(done_w[1]), 32'd1);
        chk("fb_pass", 32'(pass_w[1]), 32'd0);

        // Reset mid-run discards the partial signature
        pulse_start(1);
        send(1, 15'h1234);
        do_reset(1);
        chk("midrst_sig", 32'(sig_w[1]), 32'(SEED));
        chk("midrst_count", 32'(cnt_w[1]), 32'd0);
        chk("midrst_busy", 32'(busy_w[1]), 32'd0);
        chk("midrst_done", 32'(done_w[1]), 32'd0);
        chk("midrst_ready", 32'(ready_w[1]), 32'd0);

        // Full-length runs: correct golden, then one bit off (back-to-back)
        for (int run = 0; run < 2; run++) begin
            ref_sig = SEED;
            for (int k = 0; k < 1024; k++) begin
                vec[k]  = 15'($urandom_range(32767));
                ref_sig = mstep(ref_sig, vec[k]);
            end
            gold_v[2] = (run == 0) ? ref_sig : (ref_sig ^ (15'h1 << $urandom_range(14)));
            pulse_start(2);
            for (int k = 0; k < 1024; k++) begin
                if ($urandom_range(7) == 0) tick();
                send(2, vec[k]);
            end
            wait_done(2, 20);
            chk("full_sig", 32'(sig_w[2]), 32'(ref_sig));
            chk("full_count", 32'(cnt_w[2]), 32'd1024);
            chk("full_pass", 32'(pass_w[2]), (run == 0) ? 32'd1 : 32'd0);
        end

        tick(3);
        chk("acc_queue_empty", 32'(acc_q.size()), 32'd0);
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/test_06_resp_misr.md
# test_06_resp_misr

Response compactor that sits directly downstream of the `test_06` combinational block. It consumes the 15-bit output vector N19..N33 through a valid/ready handshake. It folds a fixed number of response vectors into a 15-bit multiple-input signature register (MISR), then compares the final signature against a golden value. The block gives the test harness a single pass/fail verdict per run instead of per-vector checking.

## Interface
- `WIDTH`, 15: response and signature width; bit i of the response corresponds to output N(19+i).
- `NUM_PATTERNS`, 1024: responses accepted per run; legal range 1..65535.
- `POLY`, 15'h0003: Galois feedback taps (x^15 + x + 1, primitive).
- `SEED`, 15'h0000: signature value loaded at run start.
- `CNT_W`, $clog2(NUM_PATTERNS+1): width of the pattern counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a run.
- `resp_valid`  in  1  upstream response vector present.
- `resp_data`  in  WIDTH  response vector {N33..N19}.
- `resp_ready`  out  1  block accepts a vector this cycle.
- `golden`  in  WIDTH  expected final signature; must be stable from `start` until `done`.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; verdict valid.
- `pass`  out  1  final signature equals `golden`; meaningful only while `done`=1.
- `signature`  out  WIDTH  current MISR contents.
- `count`  out  CNT_W  responses accepted in the current run.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 → RUN.
  - On that transition, `signature` ← SEED and `count` ← 0.
- **RUN**
  - `resp_ready`=1 and `busy`=1.
  - An accept occurs on an edge where `resp_valid` & `resp_ready`.
  - On accept: `sig_next` = ({sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0)) ^ resp_data. `signature` ← `sig_next` and `count` ← count+1.
  - On the accept where count == NUM_PATTERNS-1: go to DONE and register `pass` ← (sig_next == golden).
  - `resp_valid`=0 stalls the run indefinitely; signature and count hold.
  - `start` is ignored in RUN.
- **DONE**
  - `done`=1, `resp_ready`=0; `signature`, `count` and `pass` hold.
  - `start`=1 → RUN with SEED and count 0 reloaded (back-to-back runs need no pass through IDLE).
- `resp_data` is never sampled unless an accept occurs. `resp_valid` outside RUN has no effect.
- `rst` (in any state, including mid-run) → IDLE.
  - Reset values: `signature`=SEED, `count`=0, `busy`=0, `done`=0, `pass`=0, `resp_ready`=0.
  - A partial signature is discarded.
- `rst` has priority over `start` in the same cycle.

## Timing
- `start` sampled at edge T → `busy`/`resp_ready` high from T+1; first accept possible at edge T+1.
- Accept at edge T → `signature`/`count` updated after T (one-cycle latency).
- Final accept at edge T → `done`=1, `busy`=0, `resp_ready`=0, `pass` valid, all after T.
- Minimum run: NUM_PATTERNS+1 cycles from `start` to `done`.
- `resp_ready` is a registered state decode: no combinational path from `resp_valid` to `resp_ready`.
- `pass` and `done` are registered; `golden` only needs to meet setup at the final accept edge.

## Test plan
- **Reset values:** NUM_PATTERNS=2; hold `rst` 2 cycles → `signature`=0x0000, `count`=0, `busy`=`done`=`pass`=`resp_ready`=0.
- **Basic pass:** NUM_PATTERNS=2, SEED=0, golden=0x4002; `start`, then accept 0x0001, 0x4000 → `signature` 0x0001 then 0x4002; `done`=1, `pass`=1 one cycle after the 2nd accept.
- **Feedback and fail:** NUM_PATTERNS=3, golden=0x0007; accept 0x4000, 0x0000, 0x0000 → `signature` 0x4000, 0x0003, 0x0006; `done`=1, `pass`=0.
- **Stalls:** NUM_PATTERNS=2, same data as basic pass with `resp_valid` low 5 cycles between vectors → identical final 0x4002; `count` holds at 1 during the stall.
- **Control edge cases:**
  - `start` pulsed mid-RUN → ignored.
  - `start` in DONE → new run from SEED, `count`=0, `done`=0 next cycle.
  - `rst` after 1 of 3 accepts → IDLE, `signature`=SEED.
- **Full-length run:** NUM_PATTERNS=1024 with a random vector stream → `signature` and `pass` match a reference model for both correct and off-by-one-bit golden values.
